code_loader: RTL

//  Writer side of the CPU code-memory interface. Receives a framed program image as a

---
 rtl/code_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/code_loader.sv
// Code-RAM loader: parses SYNC_B, LEN_H, LEN_L, LEN x {lo, hi} [, CSUM] and writes words from address 0.
// Optional trailing checksum byte enabled by defining CODE_LOADER_CSUM_EN.
module code_loader #(
  parameter int          ADDR_W = 16,
  parameter logic [7:0]  SYNC_B = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  typedef enum logic [3:0] {
    ST_SYNC, ST_LEN_H, ST_LEN_L, ST_DATA_L, ST_DATA_H,
    ST_WRITE, ST_CSUM, ST_DONE, ST_ERR
  } state_t;

`ifdef CODE_LOADER_CSUM_EN
  localparam state_t ST_LAST = ST_CSUM;
`else
  localparam state_t ST_LAST = ST_DONE;
`endif

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        word_count_q, word_count_d;
  logic [15:0]        length_q, length_d;
  logic [7:0]         lo_q, lo_d;
`ifdef CODE_LOADER_CSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic        acc;
  logic [15:0] wc_inc;

  assign acc    = in_valid & in_ready_q;
  assign wc_inc = word_count_q + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:   if (acc && in_byte == SYNC_B) state_d = ST_LEN_H;
      ST_LEN_H:  if (acc) state_d = ST_LEN_L;
      ST_LEN_L:  if (acc) state_d = ({length_q[15:8], in_byte} == 16'd0) ? ST_LAST : ST_DATA_L;
      ST_DATA_L: if (acc) state_d = ST_DATA_H;
      ST_DATA_H: if (acc) state_d = ST_WRITE;
      ST_WRITE:  state_d = (wc_inc == length_q) ? ST_LAST : ST_DATA_L;
`ifdef CODE_LOADER_CSUM_EN
      ST_CSUM:   if (acc) state_d = (sum_q + in_byte == 8'd0) ? ST_DONE : ST_ERR;
`endif
      ST_DONE,
      ST_ERR:    if (start) state_d = ST_SYNC;
      default:   state_d = ST_SYNC;
    endcase
  end

  // Datapath: byte capture, address/count stepping and running checksum.
  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    word_count_d = word_count_q;
    length_d     = length_q;
    lo_d         = lo_q;
`ifdef CODE_LOADER_CSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_SYNC: begin
`ifdef CODE_LOADER_CSUM_EN
        sum_d = 8'd0;
`endif
        if (acc && in_byte == SYNC_B) begin
          mem_addr_d   = '0;
          word_count_d = 16'd0;
        end
      end
      ST_LEN_H:  if (acc) length_d[15:8] = in_byte;
      ST_LEN_L:  if (acc) length_d[7:0]  = in_byte;
      ST_DATA_L: if (acc) lo_d = in_byte;
      ST_DATA_H: if (acc) mem_wdata_d = {in_byte, lo_q};
      ST_WRITE: begin
        mem_addr_d   = mem_addr_q + ADDR_W'(1);
        word_count_d = wc_inc;
      end
      default: ;
    endcase
`ifdef CODE_LOADER_CSUM_EN
    if (acc && state_q != ST_SYNC) sum_d = sum_q + in_byte;
`endif
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    in_ready_d = (state_d == ST_SYNC)   || (state_d == ST_LEN_H)  ||
                 (state_d == ST_LEN_L)  || (state_d == ST_DATA_L) ||
                 (state_d == ST_DATA_H) || (state_d == ST_CSUM);
    mem_we_d   = (state_d == ST_WRITE);
    cpu_hold_d = (state_d != ST_DONE);
    busy_d     = (state_d != ST_DONE) && (state_d != ST_ERR);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 16'd0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= 16'd0;
      length_q     <= 16'd0;
      lo_q         <= 8'd0;
`ifdef CODE_LOADER_CSUM_EN
      sum_q        <= 8'd0;
`endif
    end else begin
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
      length_q     <= length_d;
      lo_q         <= lo_d;
`ifdef CODE_LOADER_CSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule
